// File: rtl/rx_pkg.sv
// Shared RX-chain types and constants: QPSK bit pair, default geometry,
// the 802.11a data-bin mask and constant helpers for mask checks.
package rx_pkg;

    typedef logic [1:0] qpsk_pair_t;  // {b1 (real sign), b2 (imag sign)}

    localparam int WORD_LENGTH_DFLT = 16;
    localparam int N_FFT_DFLT       = 64;
    localparam int MASK_W           = 256;

    // DC, guard bins and pilots 7/21/43/57 cleared; 48 data bins remain.
    localparam logic [63:0] DATA_MASK_80211A = 64'hFDFF_F7C0_07DF_FF7E;

    function automatic int popcount(input logic [MASK_W-1:0] v);
        int n = 0;
        for (int i = 0; i < MASK_W; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int highest_set(input logic [MASK_W-1:0] v);
        int h = -1;
        for (int i = 0; i < MASK_W; i++) if (v[i]) h = i;
        return h;
    endfunction

endpackage

// File: rtl/qpsk_symbol_demap_ctrl_if.sv
// FFT sample stream in, demapped byte stream out.
// Both streams use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; the source holds its payload while valid & !ready.
interface qpsk_symbol_demap_ctrl_if #(
    parameter int WORD_LENGTH = 16
) ();
    logic                   fft_vld;
    logic                   fft_sop;
    logic [WORD_LENGTH-1:0] fft_real;
    logic [WORD_LENGTH-1:0] fft_imag;
    logic                   fft_rdy;
    logic [7:0]             out_byte;
    logic                   out_last;
    logic                   out_vld;
    logic                   out_rdy;

    modport master (
        output fft_vld, fft_sop, fft_real, fft_imag, out_rdy,
        input  fft_rdy, out_byte, out_last, out_vld
    );

    modport slave (
        input  fft_vld, fft_sop, fft_real, fft_imag, out_rdy,
        output fft_rdy, out_byte, out_last, out_vld
    );
endinterface

// File: rtl/qpsk_byte_fifo.sv
// Small synchronous FIFO of {last, byte}; the head entry is always visible on
// pop_data, and storage resets to zero so the idle output is deterministic.
module qpsk_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & (count != CW'(DEPTH));
    assign do_pop   = pop & (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/qpsk_symbol_demap_ctrl.sv
// Per-symbol QPSK demapper: tracks the FFT bin index, skips non-data bins,
// sign-decides each data bin and packs pairs MSB-first into buffered bytes.
module qpsk_symbol_demap_ctrl
    import rx_pkg::*;
#(
    parameter int               WORD_LENGTH = WORD_LENGTH_DFLT,
    parameter int               N_FFT       = N_FFT_DFLT,
    parameter logic [N_FFT-1:0] DATA_MASK   = DATA_MASK_80211A,
    parameter int               FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    qpsk_symbol_demap_ctrl_if.slave  bus,
    output logic                     sym_done,
    output logic                     sync_err,
    output logic [0:0]               state_dbg
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int BIN_W    = $clog2(N_FFT);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int LAST_BIN = highest_set(MASK_W'(DATA_MASK));

    // Bytes must never straddle symbols, so a symbol must carry whole bytes.
    if (((popcount(MASK_W'(DATA_MASK)) * 2) % 8) != 0) begin : g_mask_chk
        $error("DATA_MASK data-bin count does not yield whole bytes per symbol");
    end

    logic [0:0]       state;
    logic [BIN_W-1:0] bin_idx;
    logic [BIN_W-1:0] cur_bin;
    logic [5:0]       pack_reg;
    logic [5:0]       pack_base;
    logic [1:0]       pair_cnt;
    logic [1:0]       cnt_base;
    qpsk_pair_t       pair;
    logic             fft_rdy;
    logic             accept;
    logic             restart;
    logic             process;
    logic             is_data;
    logic             push;
    logic [8:0]       push_data;
    logic [8:0]       pop_data;
    logic             pop;
    logic [CW-1:0]    fifo_count;

    assign fft_rdy     = fifo_count < CW'(FIFO_DEPTH);
    assign bus.fft_rdy = fft_rdy;
    assign accept      = bus.fft_vld & fft_rdy;
    assign restart     = accept & bus.fft_sop;
    // In IDLE only an sop beat starts a symbol; stray beats are swallowed.
    assign process     = accept & ((state == ST_RUN) | bus.fft_sop);

    // An sop beat is always bin 0 and abandons any partial byte.
    assign cur_bin   = bus.fft_sop ? '0 : bin_idx;
    assign pack_base = bus.fft_sop ? '0 : pack_reg;
    assign cnt_base  = bus.fft_sop ? '0 : pair_cnt;

    assign is_data   = DATA_MASK[cur_bin];
    assign pair      = {bus.fft_real[WORD_LENGTH-1], bus.fft_imag[WORD_LENGTH-1]};
    assign push      = process & is_data & (cnt_base == 2'd3);
    assign push_data = {(cur_bin == BIN_W'(LAST_BIN)), pack_base, pair};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bin_idx  <= '0;
            pack_reg <= '0;
            pair_cnt <= '0;
            sym_done <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sym_done <= 1'b0;
            sync_err <= restart & (state == ST_RUN);
            if (process) begin
                if (is_data) begin
                    pack_reg <= {pack_base[3:0], pair};
                    pair_cnt <= cnt_base + 2'd1;
                end else begin
                    pack_reg <= pack_base;
                    pair_cnt <= cnt_base;
                end
                if (cur_bin == BIN_W'(N_FFT - 1)) begin
                    bin_idx  <= '0;
                    state    <= ST_IDLE;
                    sym_done <= 1'b1;
                end else begin
                    bin_idx  <= cur_bin + BIN_W'(1);
                    state    <= ST_RUN;
                end
            end
        end
    end

    assign pop         = bus.out_vld & bus.out_rdy;
    assign bus.out_vld = (fifo_count != '0);
    assign bus.out_last = pop_data[8];
    assign bus.out_byte = pop_data[7:0];
    assign state_dbg   = state;

    qpsk_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_qpsk_symbol_demap_ctrl.sv
// Bench for qpsk_symbol_demap_ctrl: decision table, directed corner sequences
// and random symbols checked against a bit-list reference model.
module tb_qpsk_symbol_demap_ctrl;

    localparam logic [63:0] MASK = 64'hFDFF_F7C0_07DF_FF7E;

    typedef struct packed {
        logic [3:0][15:0] re;
        logic [3:0][15:0] im;
        logic [7:0]       exp_byte;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_done;
    logic       sync_err;
    logic [0:0] state_dbg;

    int         n_checks = 0;
    int         n_errors = 0;
    int         rx_count = 0;
    int         sym_done_cnt = 0;
    int         exp_done = 0;
    int         last_bin = 0;
    bit         rand_rdy = 0;
    logic [8:0] exp_q[$];
    logic [15:0] sym_re[64];
    logic [15:0] sym_im[64];
    vec_t       vecs[12];
    bit         prev_stall = 0;
    logic [8:0] prev_word = '0;

    always #5 clk = ~clk;

    qpsk_symbol_demap_ctrl_if #(.WORD_LENGTH(16)) bus ();

    qpsk_symbol_demap_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sym_done  (sym_done),
        .sync_err  (sync_err),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the beat until it is taken; inputs always change 1 after posedge.
    task automatic send_beat(input logic sop, input logic [15:0] re, input logic [15:0] im);
        int waited = 0;
        bus.fft_vld  = 1'b1;
        bus.fft_sop  = sop;
        bus.fft_real = re;
        bus.fft_imag = im;
        while (!bus.fft_rdy && waited < 200) begin
            idle(1);
            waited++;
        end
        if (!bus.fft_rdy) check("fft_rdy_timeout", 32'(bus.fft_rdy), 32'd1);
        idle(1);
        bus.fft_vld = 1'b0;
        bus.fft_sop = 1'b0;
    endtask

    task automatic send_symbol(input int nbins, input bit gaps, input bit expect_sync);
        for (int k = 0; k < nbins; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat(k == 0, sym_re[k], sym_im[k]);
            if (k == 0) check("sync_err", 32'(sync_err), 32'(expect_sync));
            if (k == 62) check("sym_done_early", 32'(sym_done), 32'd0);
            if (k == 63) check("sym_done", 32'(sym_done), 32'd1);
        end
        if (nbins == 64) exp_done++;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) begin
            sym_re[k] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            sym_im[k] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        end
    endtask

    // Reference: list every decided bit of the first nbins bins in bin order,
    // then cut the list into 8-bit bytes; trailing bits are a discarded partial.
    task automatic model_symbol(input int nbins);
        bit bits[$];
        int pair_bin[$];
        int val;
        for (int k = 0; k < nbins; k++) begin
            if (MASK[k]) begin
                bits.push_back($signed(sym_re[k]) < 0);
                bits.push_back($signed(sym_im[k]) < 0);
                pair_bin.push_back(k);
            end
        end
        for (int b = 0; b + 8 <= bits.size(); b += 8) begin
            val = 0;
            for (int i = 0; i < 8; i++) val = val * 2 + int'(bits[b + i]);
            exp_q.push_back({(pair_bin[b / 2 + 3] == last_bin), 8'(val)});
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            idle(1);
            w++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic vec_t mk(input int r0, input int i0, input int r1, input int i1,
                                input int r2, input int i2, input int r3, input int i3,
                                input logic [7:0] e);
        vec_t v;
        v.re[0] = 16'(r0); v.im[0] = 16'(i0);
        v.re[1] = 16'(r1); v.im[1] = 16'(i1);
        v.re[2] = 16'(r2); v.im[2] = 16'(i2);
        v.re[3] = 16'(r3); v.im[3] = 16'(i3);
        v.exp_byte = e;
        return v;
    endfunction

    // Scoreboard and output-hold monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            got = {bus.out_last, bus.out_byte};
            if (prev_stall && bus.out_vld) check("out_hold", 32'(got), 32'(prev_word));
            if (bus.out_vld && bus.out_rdy) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 32'(got), 32'(e));
                end
            end
            if (sym_done) sym_done_cnt++;
            prev_stall = bus.out_vld && !bus.out_rdy;
            prev_word  = got;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int base;
        int d;
        bus.fft_vld  = 1'b0;
        bus.fft_sop  = 1'b0;
        bus.fft_real = '0;
        bus.fft_imag = '0;
        bus.out_rdy  = 1'b1;
        for (int k = 0; k < 64; k++) if (MASK[k]) last_bin = k;

        vecs[0]  = mk(100, 100, -100, -100, 100, -100, -100, 100, 8'h36);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[2]  = mk(-1, -1, -1, -1, -1, -1, -1, -1, 8'hFF);
        vecs[3]  = mk(0, -1, 0, -1, 0, -1, 0, -1, 8'h55);
        vecs[4]  = mk(-32768, 0, -32768, 0, -32768, 0, -32768, 0, 8'hAA);
        vecs[5]  = mk(32767, 32767, -32768, -32768, 0, 0, -1, 0, 8'h32);
        vecs[6]  = mk(-5, 3, 7, -9, 1, 1, -2, -2, 8'h93);
        vecs[7]  = mk(1, 1, 1, 1, 1, 1, -1, -1, 8'h03);
        vecs[8]  = mk(-1, -1, 1, 1, 1, 1, 1, 1, 8'hC0);
        vecs[9]  = mk(0, -7, -7, 0, 0, -7, -7, 0, 8'h66);
        vecs[10] = mk(-3, -3, -3, -3, 3, 3, 3, 3, 8'hF0);
        vecs[11] = mk(3, 3, 3, 3, -3, -3, -3, -3, 8'h0F);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_sym_done", 32'(sym_done), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_fft_rdy", 32'(bus.fft_rdy), 32'd1);
        check("rst_out_word", 32'({bus.out_last, bus.out_byte}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Reset mid-stream, then a clean symbol
        fill_random();
        model_symbol(20);
        send_symbol(20, 0, 0);
        idle(3);
        check("pre_reset_state", 32'(state_dbg), 32'd1);
        rst_n = 1'b0;
        idle(2);
        check("in_reset_out_vld", 32'(bus.out_vld), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_out_vld", 32'(bus.out_vld), 32'd0);
        check("post_reset_state", 32'(state_dbg), 32'd0);
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);
        idle(1);
        base = rx_count;
        fill_random();
        model_symbol(64);
        send_symbol(64, 0, 0);
        drain();
        check("t1_bytes", 32'(rx_count - base), 32'd12);

        // Constant symbol: real +100, imag -5
        for (int k = 0; k < 64; k++) begin
            sym_re[k] = 16'd100;
            sym_im[k] = 16'hFFFB;
        end
        for (int j = 0; j < 12; j++) exp_q.push_back({(j == 11), 8'h55});
        base = rx_count;
        send_symbol(64, 0, 0);
        drain();
        check("t2_bytes", 32'(rx_count - base), 32'd12);

        // Decision table, one entry per byte of the symbol
        d = 0;
        for (int k = 0; k < 64; k++) begin
            sym_re[k] = 16'($urandom);
            sym_im[k] = 16'($urandom);
            if (MASK[k]) begin
                sym_re[k] = vecs[d / 4].re[d % 4];
                sym_im[k] = vecs[d / 4].im[d % 4];
                d++;
            end
        end
        for (int j = 0; j < 12; j++) exp_q.push_back({(j == 11), vecs[j].exp_byte});
        base = rx_count;
        send_symbol(64, 0, 0);
        drain();
        check("t3_bytes", 32'(rx_count - base), 32'd12);

        // Beats before any sop are discarded
        base = rx_count;
        for (int k = 0; k < 10; k++) send_beat(1'b0, 16'($urandom), 16'($urandom));
        idle(4);
        check("t4_no_bytes", 32'(rx_count - base), 32'd0);
        check("t4_state", 32'(state_dbg), 32'd0);
        fill_random();
        model_symbol(64);
        send_symbol(64, 0, 0);
        drain();
        check("t4_bytes", 32'(rx_count - base), 32'd12);

        // sop at bin 30 restarts the symbol
        base = rx_count;
        fill_random();
        model_symbol(30);
        send_symbol(30, 0, 0);
        fill_random();
        model_symbol(64);
        send_symbol(64, 0, 1);
        drain();
        check("t5_bytes", 32'(rx_count - base), 32'd18);

        // Backpressure: out_rdy low for 40 cycles
        base = rx_count;
        fill_random();
        model_symbol(64);
        fork
            begin
                bus.out_rdy = 1'b0;
                idle(40);
                check("t6_fft_rdy_low", 32'(bus.fft_rdy), 32'd0);
                check("t6_out_vld", 32'(bus.out_vld), 32'd1);
                bus.out_rdy = 1'b1;
            end
            send_symbol(64, 0, 0);
        join
        drain();
        check("t6_bytes", 32'(rx_count - base), 32'd12);

        // Random symbols with gaps and random backpressure
        rand_rdy = 1;
        for (int s = 0; s < 4; s++) begin
            fill_random();
            model_symbol(64);
            send_symbol(64, 1, 0);
        end
        rand_rdy = 0;
        idle(2);
        bus.out_rdy = 1'b1;
        drain();

        idle(3);
        check("sym_done_total", 32'(sym_done_cnt), 32'(exp_done));
        check("final_state", 32'(state_dbg), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
